// File: rtl/alu_operand_stage.sv
// ---------------------------------------------------------------------------
// alu_operand_stage
//
// Operand-issue stage in front of the 8-bit ALU. It accepts decoded
// instructions over a valid/ready handshake and reads a 4-entry register
// file. It drives opcode and operands into the ALU, then writes the ALU
// result back one cycle later. A dependency on the op sitting in the issue
// register costs one bubble. A dependency on the op in the result tracker is
// bypassed straight from z_i. The ALU zero/overflow flags are held in a flag
// register.
//
// Instruction format: [7:4] op, [3:2] rd (also source A), [1:0] rs (source B)
//   op 0..D : ALU op, opcode passed through, writes R[rd]
//   op E    : CMP, issues CMP_OP, updates flags only
//   op F    : NOP, accepted but never issued
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   instr_valid_i/instr_i instruction offer
//   instr_ready_o         stage can accept this cycle
//   opcode_o, a_o, b_o    to ALU opcode / a_i / b_i
//   alu_valid_o           issue register holds a live op
//   z_i, zero_i, ovrflw_i ALU result and flags, valid the cycle after issue
//   flags_o               {ovrflw, zero} of the last completed non-NOP op
//   wb_en_o, wb_addr_o,
//   wb_data_o             register write happening this cycle
// ---------------------------------------------------------------------------
module alu_operand_stage #(
    parameter int          DATA_W = 8,
    parameter logic [3:0]  CMP_OP = 4'h1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid_i,
    input  logic [7:0]        instr_i,
    output logic              instr_ready_o,
    output logic [3:0]        opcode_o,
    output logic [DATA_W-1:0] a_o,
    output logic [DATA_W-1:0] b_o,
    output logic              alu_valid_o,
    input  logic [DATA_W-1:0] z_i,
    input  logic              zero_i,
    input  logic              ovrflw_i,
    output logic [1:0]        flags_o,
    output logic              wb_en_o,
    output logic [1:0]        wb_addr_o,
    output logic [DATA_W-1:0] wb_data_o
);

    localparam logic [3:0] OP_CMP = 4'hE;
    localparam logic [3:0] OP_NOP = 4'hF;

    // Incoming instruction fields
    logic [3:0] in_op;
    logic [1:0] in_rd;
    logic [1:0] in_rs;

    assign in_op = instr_i[7:4];
    assign in_rd = instr_i[3:2];
    assign in_rs = instr_i[1:0];

    // Architectural state
    logic [DATA_W-1:0] rf [4];
    logic [1:0]        flags_q;

    // Issue register (I)
    logic              i_valid;
    logic              i_wr;
    logic [1:0]        i_rd;
    logic [3:0]        opcode_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;

    // Result tracker (R)
    logic              r_valid;
    logic              r_wr;
    logic [1:0]        r_rd;

    logic              hazard;
    logic              accept;
    logic              issue;
    logic [DATA_W-1:0] opa;
    logic [DATA_W-1:0] opb;

    // Operand read with bypass, and hazard detection against the issue register.
    // The op in R is writing back on this very edge, so its result comes
    // from z_i rather than the stale register file. The op in I has no
    // result yet, which forces a one-cycle stall.
    always_comb begin
        // NOTE: every signal gets a default before any condition; a path that leaves one unassigned would infer a latch.
        hazard = 1'b0;
        opa    = rf[in_rd];
        opb    = rf[in_rs];
        if (i_valid && i_wr && (in_op != OP_NOP) && ((i_rd == in_rd) || (i_rd == in_rs)))
            hazard = 1'b1;
        if (r_valid && r_wr && (r_rd == in_rd))
            opa = z_i;
        if (r_valid && r_wr && (r_rd == in_rs))
            opb = z_i;
    end

    assign instr_ready_o = !hazard && rst_n;
    assign accept        = instr_valid_i && instr_ready_o;
    assign issue         = accept && (in_op != OP_NOP);

    // Pipeline registers: I empties unless a non-NOP op is accepted; R always
    // takes I's previous contents.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            i_valid  <= 1'b0;
            i_wr     <= 1'b0;
            i_rd     <= '0;
            opcode_q <= '0;
            a_q      <= '0;
            b_q      <= '0;
            r_valid  <= 1'b0;
            r_wr     <= 1'b0;
            r_rd     <= '0;
        end else begin
            i_valid <= issue;
            if (issue) begin
                i_wr     <= (in_op != OP_CMP);
                i_rd     <= in_rd;
                opcode_q <= (in_op == OP_CMP) ? CMP_OP : in_op;
                a_q      <= opa;
                b_q      <= opb;
            end
            r_valid <= i_valid;
            r_wr    <= i_wr;
            r_rd    <= i_rd;
        end
    end

    // Writeback and flag update on the edge that closes R's cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: the register file is reset explicitly because software relies on R0-R3 reading zero after reset.
            for (int k = 0; k < 4; k++)
                rf[k] <= '0;
            flags_q <= '0;
        end else if (r_valid) begin
            flags_q <= {ovrflw_i, zero_i};
            if (r_wr)
                rf[r_rd] <= z_i;
        end
    end

    assign opcode_o    = opcode_q;
    assign a_o         = a_q;
    assign b_o         = b_q;
    assign alu_valid_o = i_valid;
    assign flags_o     = flags_q;
    assign wb_en_o     = r_valid && r_wr;
    assign wb_addr_o   = r_rd;
    assign wb_data_o   = wb_en_o ? z_i : '0;

endmodule

// File: tb/tb_alu_operand_stage.sv
// ---------------------------------------------------------------------------
// tb_alu_operand_stage
//
// Directed bench for alu_operand_stage. It includes a small ALU responder:
//   opcode 0 : z = a + b   (signed overflow flagged)
//   opcode 1 : z = a - b   (signed overflow flagged)
//   others   : z = b + opcode  (with R[rs]=0 this loads a constant)
// It finishes with a continuous-valid random phase. A sequential reference
// model in that phase predicts every writeback, the final flags and the
// final register file.
// ---------------------------------------------------------------------------
module tb_alu_operand_stage;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       instr_valid_i;
    logic [7:0] instr_i;
    logic       instr_ready_o;
    logic [3:0] opcode_o;
    logic [7:0] a_o;
    logic [7:0] b_o;
    logic       alu_valid_o;
    logic [7:0] z_i = '0;
    logic       zero_i = 1'b0;
    logic       ovrflw_i = 1'b0;
    logic [1:0] flags_o;
    logic       wb_en_o;
    logic [1:0] wb_addr_o;
    logic [7:0] wb_data_o;

    int checks_total  = 0;
    int checks_passed = 0;

    logic [7:0] ref_rf [4];
    logic [1:0] ref_flags;
    logic [9:0] exp_q [$];

    always #5 clk = ~clk;

    alu_operand_stage #(.DATA_W(8), .CMP_OP(4'h1)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .instr_valid_i (instr_valid_i),
        .instr_i       (instr_i),
        .instr_ready_o (instr_ready_o),
        .opcode_o      (opcode_o),
        .a_o           (a_o),
        .b_o           (b_o),
        .alu_valid_o   (alu_valid_o),
        .z_i           (z_i),
        .zero_i        (zero_i),
        .ovrflw_i      (ovrflw_i),
        .flags_o       (flags_o),
        .wb_en_o       (wb_en_o),
        .wb_addr_o     (wb_addr_o),
        .wb_data_o     (wb_data_o)
    );

    // Returns {ovrflw, zero, z}
    function automatic logic [9:0] alu_f(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [7:0] z;
        logic       ov;
        ov = 1'b0;
        case (op)
            4'h0: begin z = a + b; ov = (a[7] == b[7]) && (z[7] != a[7]); end
            4'h1: begin z = a - b; ov = (a[7] != b[7]) && (z[7] != a[7]); end
            default: z = b + {4'h0, op};
        endcase
        return {ov, (z == 8'h00), z};
    endfunction

    // ALU responder: result is presented the cycle after alu_valid_o.
    always @(posedge clk) begin
        if (alu_valid_o)
            {ovrflw_i, zero_i, z_i} <= alu_f(opcode_o, a_o, b_o);
        else
            {ovrflw_i, zero_i, z_i} <= {1'b0, 1'b0, 8'hEE};
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_total++;
        assert (obs === exp) checks_passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Entered any time before the next edge; returns 1 ns after the accepting
    // edge with instr_valid_i still high (caller must change or drop it).
    task automatic send(input logic [7:0] ins, output int stalls);
        instr_valid_i = 1'b1;
        instr_i       = ins;
        stalls        = 0;
        #1;
        while (!instr_ready_o && stalls < 8) begin
            @(posedge clk);
            #1;
            stalls++;
        end
        if (stalls >= 8)
            check("send_timeout_ready", 32'(instr_ready_o), 32'h1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        instr_valid_i = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic ref_apply(input logic [7:0] ins);
        logic [3:0] op;
        logic [1:0] rd;
        logic [1:0] rs;
        logic [9:0] res;
        op = ins[7:4];
        rd = ins[3:2];
        rs = ins[1:0];
        if (op != 4'hF) begin
            res       = alu_f((op == 4'hE) ? 4'h1 : op, ref_rf[rd], ref_rf[rs]);
            ref_flags = res[9:8];
            if (op != 4'hE) begin
                ref_rf[rd] = res[7:0];
                exp_q.push_back({rd, res[7:0]});
            end
        end
    endtask

    task automatic check_wb();
        logic [9:0] e;
        if (wb_en_o) begin
            if (exp_q.size() == 0) begin
                check("wb_unexpected", 32'(wb_en_o), 32'h0);
            end else begin
                e = exp_q.pop_front();
                check("wb_addr", 32'(wb_addr_o), 32'(e[9:8]));
                check("wb_data", 32'(wb_data_o), 32'(e[7:0]));
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         s;
        int         accepted;
        logic       acc;
        logic [7:0] cur;

        // ---------------- reset / idle ----------------
        rst_n         = 1'b0;
        instr_valid_i = 1'b0;
        instr_i       = 8'h00;
        repeat (3) begin
            @(posedge clk);
            #1;
            check("rst_ready", 32'(instr_ready_o), 32'h0);
            check("rst_outputs",
                  32'({alu_valid_o, wb_en_o, opcode_o, a_o, b_o, flags_o, wb_addr_o, wb_data_o} != '0),
                  32'h0);
        end
        rst_n = 1'b1;
        #1;
        check("ready_after_release", 32'(instr_ready_o), 32'h1);

        // ---------------- preload R1=5, R2=3 ----------------
        send(8'h54, s);                 // op5 rd1 rs0 : R1 = 0 + 5
        send(8'h38, s);                 // op3 rd2 rs0 : R2 = 0 + 3
        check("preload_no_stall", 32'(s), 32'h0);
        idle(3);

        // ---------------- independent stream ----------------
        send(8'h06, s);                 // ADD r1,r2
        check("ind1_stall", 32'(s), 32'h0);
        check("ind1_issue", 32'({alu_valid_o, opcode_o, a_o, b_o}), 32'({1'b1, 4'h0, 8'd5, 8'd3}));
        send(8'h0F, s);                 // ADD r3,r3
        check("ind2_stall", 32'(s), 32'h0);
        check("ind1_wb", 32'({wb_en_o, wb_addr_o, wb_data_o}), 32'({1'b1, 2'd1, 8'd8}));
        check("ind2_issue", 32'({a_o, b_o}), 32'h0);
        idle(1);
        check("ind2_wb", 32'({wb_en_o, wb_addr_o, wb_data_o}), 32'({1'b1, 2'd3, 8'd0}));
        check("ind1_flags", 32'(flags_o), 32'h0);
        idle(1);
        check("ind2_flags_zero", 32'(flags_o), 32'h1);

        // ---------------- stall ignores valid, NOP never stalls ----------------
        send(8'h54, s);                 // reload R1 = 5
        instr_valid_i = 1'b0;
        instr_i       = 8'h06;          // rd1 matches I.rd
        #1;
        check("stall_without_valid", 32'(instr_ready_o), 32'h0);
        instr_i = 8'hF5;                // NOP with matching fields
        #1;
        check("nop_no_stall", 32'(instr_ready_o), 32'h1);
        idle(3);

        // ---------------- dependent pair ----------------
        send(8'h06, s);                 // ADD r1,r2 -> R1 = 8
        check("dep1_stall", 32'(s), 32'h0);
        send(8'h09, s);                 // ADD r2,r1 -> R2 = 3 + 8
        check("dep2_one_stall", 32'(s), 32'h1);
        check("dep2_bypass", 32'({alu_valid_o, a_o, b_o}), 32'({1'b1, 8'd3, 8'd8}));
        idle(1);
        check("dep2_wb", 32'({wb_en_o, wb_addr_o, wb_data_o}), 32'({1'b1, 2'd2, 8'd11}));
        idle(2);
        send(8'h2E, s);                 // op2 rd3 rs2 : reads R3, R2
        check("probe_r2", 32'({a_o, b_o}), 32'({8'd0, 8'd11}));
        idle(3);

        // ---------------- CMP / flags, then NOP ----------------
        send(8'hE5, s);                 // CMP r1,r1
        check("cmp_issue", 32'({opcode_o, a_o, b_o}), 32'({4'h1, 8'd8, 8'd8}));
        idle(1);
        check("cmp_no_wb", 32'(wb_en_o), 32'h0);
        idle(1);
        check("cmp_flags", 32'(flags_o), 32'h1);
        send(8'hF5, s);                 // NOP
        check("nop_not_issued", 32'(alu_valid_o), 32'h0);
        idle(1);
        check("nop_quiet", 32'({alu_valid_o, wb_en_o, flags_o}), 32'({1'b0, 1'b0, 2'b01}));

        // ---------------- reset mid-flight ----------------
        send(8'h01, s);                 // ADD r0,r1
        check("mid_issue", 32'(alu_valid_o), 32'h1);
        rst_n         = 1'b0;
        instr_valid_i = 1'b0;
        #1;
        check("mid_rst_ready", 32'(instr_ready_o), 32'h0);
        @(posedge clk);
        #1;
        check("mid_rst_cleared", 32'({alu_valid_o, wb_en_o}), 32'h0);
        @(posedge clk);
        #1;
        check("mid_rst_no_wb", 32'(wb_en_o), 32'h0);
        rst_n = 1'b1;
        #1;
        check("mid_release_ready", 32'(instr_ready_o), 32'h1);
        send(8'h21, s);                 // op2 rd0 rs1 : reads R0, R1
        check("mid_first_accept", 32'(s), 32'h0);
        check("mid_r0_r1_zero", 32'({a_o, b_o}), 32'h0);
        check("mid_flags_zero", 32'(flags_o), 32'h0);
        idle(3);

        // ---------------- continuous valid, random ops ----------------
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++)
            ref_rf[k] = 8'h00;
        ref_flags = 2'b00;
        exp_q.delete();
        accepted = 0;
        cur      = 8'($urandom);
        for (int cyc = 0; cyc < 2000 && accepted < 150; cyc++) begin
            instr_valid_i = 1'b1;
            instr_i       = cur;
            #1;
            acc = instr_ready_o;
            @(posedge clk);
            #1;
            check_wb();
            if (acc) begin
                ref_apply(cur);
                accepted++;
                cur = 8'($urandom);
            end
        end
        check("rand_all_accepted", 32'(accepted), 32'd150);
        instr_valid_i = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
            check_wb();
        end
        check("rand_wb_lost", 32'(exp_q.size()), 32'h0);
        check("rand_flags", 32'(flags_o), 32'(ref_flags));
        for (int r = 0; r < 4; r++) begin
            send({4'hE, 2'(r), 2'(r)}, s);   // CMP rr,rr exposes R[r] on a_o
            check("rand_rf", 32'(a_o), 32'(ref_rf[r]));
        end
        idle(3);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/alu_operand_stage.md
# alu_operand_stage

Operand-issue stage directly upstream of the 8-bit ALU. Accepts decoded 8-bit instructions over a valid/ready handshake, reads a 4×8 register file, and drives opcode and operands into the ALU. It captures the ALU result one cycle later and writes it back. Dependency hazards are resolved by a one-bubble stall plus a result bypass, and the ALU zero/overflow flags are held in a flag register.

## Interface
Parameters:
- `DATA_W`, 8, datapath width; register file is fixed at 4 entries.
- `CMP_OP`, 4'h1, ALU opcode issued for CMP (subtract).

Ports:
- `clk`, in, 1, single clock; all state updates on rising edge.
- `rst_n`, in, 1, reset, synchronous, active-low.
- `instr_valid_i`, in, 1, an instruction is offered.
- `instr_i`, in, 8, instruction fields:
  - [7:4] op
  - [3:2] rd (also source A)
  - [1:0] rs (source B)
- `instr_ready_o`, out, 1, stage can accept this cycle.
- `opcode_o`, out, 4, to ALU `opcode`.
- `a_o`, out, DATA_W, to ALU `a_i`.
- `b_o`, out, DATA_W, to ALU `b_i`.
- `alu_valid_o`, out, 1, issue register holds a live op.
- `z_i`, in, DATA_W, ALU result; valid the cycle after `alu_valid_o`.
- `zero_i`, in, 1, ALU zero flag, same timing as `z_i`.
- `ovrflw_i`, in, 1, ALU overflow flag, same timing as `z_i`.
- `flags_o`, out, 2, {ovrflw, zero} from the last completed non-NOP op.
- `wb_en_o`, out, 1, register write this cycle.
- `wb_addr_o`, out, 2, register being written.
- `wb_data_o`, out, DATA_W, value being written (equals `z_i` when `wb_en_o`=1).

## Operation
- Op classes:
  - op 4'h0–4'hD: ALU op; `opcode_o`=op; writes R[rd].
  - op 4'hE: CMP; `opcode_o`=`CMP_OP`; updates flags only, no writeback.
  - op 4'hF: NOP; accepted, never issued.
- Pipeline:
  - Issue register (I) is loaded on accept.
  - Result tracker (R) is loaded from I on the next edge.
  - On R's cycle, `z_i`/`zero_i`/`ovrflw_i` are sampled. Writeback and flag update happen on that edge.
- Operand read, at accept: A=R[rd], B=R[rs]. If R is live, writes, and its rd matches a source, that source takes `z_i` (bypass).
- Hazard: if I is live and writes, and I.rd equals the incoming rd or rs, then `instr_ready_o`=0 (stall).
  - Stall does not depend on `instr_valid_i`.
  - NOP never stalls.
- `instr_ready_o` is combinational: !hazard && rst_n.
- If no accept occurs on an edge, I becomes empty (`alu_valid_o`=0). R always takes I's previous contents.
- Register file write and the same-cycle operand read of the same register: the read uses the bypassed new value, never the stale one.
- Arithmetic is entirely in the ALU. This stage is width-preserving; there is no truncation or extension.

## Timing
- Reset (`rst_n`=0 at an edge):
  - R0–R3=0; `flags_o`=0.
  - I and R are cleared: `alu_valid_o`=0, `wb_en_o`=0.
  - `opcode_o`=0, `a_o`=0, `b_o`=0, `wb_addr_o`=0, `wb_data_o`=0.
  - `instr_ready_o`=0 while `rst_n`=0.
- Reset mid-operation: in-flight I/R ops are discarded with no writeback and no flag change. The first accept is possible in the first cycle with `rst_n`=1.
- Latency, for an instruction accepted at edge N:
  - `alu_valid_o`=1 in cycle N+1.
  - `z_i` is sampled in cycle N+2.
  - R[rd] and flags are updated at the end of cycle N+2.
  - `wb_en_o`=1 during cycle N+2.
- Throughput: 1 op/cycle for independent ops. A dependent op immediately following costs exactly 1 stall cycle.
- Handshake: a transfer occurs iff `instr_valid_i`&&`instr_ready_o` at an edge. The upstream block holds `instr_i` stable while stalled.

## Test plan
- Reset/idle: hold `rst_n`=0 for 3 cycles, release.
  - During reset: `instr_ready_o`=0 and all outputs 0.
  - Cycle 1 after release: `instr_ready_o`=1.
- Independent stream: bench ALU model returns z=a+b on op 4'h0.
  - Preload R1=5, R2=3 via ops against the zero-reset registers.
  - Issue ADD r1,r2 then ADD r3,r3 back-to-back: no stall; R1=8 two cycles after the first accept.
- Dependent pair: ADD r1,r2 then ADD r2,r1.
  - `instr_ready_o`=0 for exactly one cycle.
  - Second op issues with a_o=3, b_o=8 (bypassed), giving R2=11.
- CMP/flags: CMP r1,r1 with model zero_i=1.
  - `flags_o`=2'b01; `wb_en_o` stays 0.
  - Then NOP: `alu_valid_o` stays 0 and `flags_o` is unchanged.
- Reset mid-flight: accept ADD r0,r1, assert `rst_n`=0 the next cycle.
  - No writeback occurs; R0=0 and flags=0 after release.
- Continuous valid with random rd/rs: scoreboard check that the register file matches a sequential reference model and no op is lost or duplicated.
